fn_suma_resta_sync: RTL and testbench
=====================================

// Module: fn_suma_resta_sync
// PURPOSE
//  32-bit two's-complement adder/subtractor for the RV32I datapath ALU (ADD/ADDI/SUB, address calc).
//  Single control bit selects Y = a + b (resta=0) or Y = a - b (resta=1), computed as a + ~b + 1.
//  Result and status flags are registered: one-cycle latency.
//  Flags feed branch-compare logic (BEQ/BNE/BLT/BGE/BLTU/BGEU).
// PARAMETERS
//  WIDTH     32  operand/result width in bits; all widths below scale with it
// PORTS
//  clk       in   1      system clock, all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  a         in   WIDTH  operand A
//  b         in   WIDTH  operand B
//  resta     in   1      0 = add, 1 = subtract (a - b)
//  Y         out  WIDTH  registered result, modulo 2^WIDTH
//  carry     out  1      registered carry-out of MSB adder stage
//  overflow  out  1      registered signed overflow
//  zero      out  1      registered, 1 when Y == 0
//  negative  out  1      registered, copy of Y[WIDTH-1]
// BEHAVIOUR
//  - Sync reset: on rising clk with rst=1, Y=0, carry=0, overflow=0, zero=1, negative=0.
//    rst has priority over all inputs. No async path.
//  - Core: bb = b XOR {WIDTH{resta}}; {cout,sum} = a + bb + resta (carry-in = resta).
//    Combinational sum; no intermediate pipeline stage.
//  - Latency: inputs sampled at edge N, outputs valid after edge N, held until next edge.
//    No enable, no handshake. Every non-reset edge reloads all outputs.
//  - Widths: Y is low WIDTH bits of the sum; bit WIDTH goes to carry; no saturation.
//  - carry: raw cout.
//    In subtract mode carry=1 means no borrow (a >= b unsigned); BLTU = ~carry.
//  - overflow = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
//    Add example: 0x7FFFFFFF+1. Sub example: 0x80000000-1.
//  - zero = (sum == 0), evaluated on the new result in the same cycle it is registered.
//  - negative = sum[MSB]. Signed less-than for consumers is negative XOR overflow.
//  - Boundaries:
//    - a - a gives Y=0, zero=1, carry=1, overflow=0.
//    - 0 - 1 gives Y=0xFFFFFFFF, carry=0.
//    - 0xFFFFFFFF + 1 gives Y=0, carry=1, zero=1.
//    - resta toggling every cycle is legal; each cycle is independent.
//  - Reset mid-stream: the result of the operation presented during the rst edge is discarded;
//    the first post-reset result appears one edge after rst deasserts.
//  - Inputs are X-free assumed at sampling edges; no internal state besides output registers.
// TESTING
//  1 rst=1 for 2 edges -> Y=0, zero=1, carry=0, overflow=0, negative=0
//  2 a=15, b=10, resta=0, one edge -> Y=25, zero=0, carry=0, overflow=0
//  3 a=15, b=10, resta=1, one edge -> Y=5, carry=1, overflow=0, negative=0
//  4 a=10, b=15, resta=1 -> Y=0xFFFFFFFB, carry=0, negative=1
//    then a=0x7FFFFFFF, b=1, resta=0 -> Y=0x80000000, overflow=1
//  5 a=0x80000000, b=1, resta=1 -> Y=0x7FFFFFFF, overflow=1, carry=1
//    then a=b=0x12345678, resta=1 -> Y=0, zero=1
//  6 Back-to-back: alternate resta each cycle with random a/b;
//    compare against a reference model delayed one cycle.
//    Assert rst mid-stream -> reset values next edge, previous op discarded.

Source files
------------

// File: rtl/fn_suma_resta_sync.sv
// rtl/fn_suma_resta_sync.sv - registered two's-complement adder/subtractor with ALU status flags
module fn_suma_resta_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             resta,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Subtraction is a + ~b + 1: resta both inverts b and supplies the carry-in.
  always_comb begin
    bb          = b ^ {WIDTH{resta}};
    {cout, sum} = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, resta};
    ovf         = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Y        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      Y        <= sum;
      carry    <= cout;
      overflow <= ovf;
      zero     <= (sum == '0);
      negative <= sum[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_fn_suma_resta_sync.sv
// tb/tb_fn_suma_resta_sync.sv - directed self-checking bench for fn_suma_resta_sync
module tb_fn_suma_resta_sync;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        resta;
  logic [31:0] Y;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int total = 0;
  int bad   = 0;

  fn_suma_resta_sync #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .resta    (resta),
    .Y        (Y),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [31:0] ta, input logic [31:0] tb, input logic tr);
    a = ta;
    b = tb;
    resta = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(32'h1234_5678, 32'h1111_1111, 1'b0);
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    total++; if (Y !== 32'h0)      begin bad++; $display("FAIL reset_Y got=%h exp=%h", Y, 32'h0); end
    total++; if (zero !== 1'b1)    begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
    total++; if (carry !== 1'b0)   begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (negative !== 1'b0) begin bad++; $display("FAIL reset_negative got=%b exp=0", negative); end
    rst = 1'b0;
  endtask

  task automatic test_add;
    step(32'd15, 32'd10, 1'b0);
    total++; if (Y !== 32'd25)      begin bad++; $display("FAIL add_Y got=%h exp=%h", Y, 32'd25); end
    total++; if (zero !== 1'b0)     begin bad++; $display("FAIL add_zero got=%b exp=0", zero); end
    total++; if (carry !== 1'b0)    begin bad++; $display("FAIL add_carry got=%b exp=0", carry); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL add_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_sub;
    step(32'd15, 32'd10, 1'b1);
    total++; if (Y !== 32'd5)       begin bad++; $display("FAIL sub_Y got=%h exp=%h", Y, 32'd5); end
    total++; if (carry !== 1'b1)    begin bad++; $display("FAIL sub_carry got=%b exp=1", carry); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sub_overflow got=%b exp=0", overflow); end
    total++; if (negative !== 1'b0) begin bad++; $display("FAIL sub_negative got=%b exp=0", negative); end
  endtask

  task automatic test_borrow_and_add_overflow;
    step(32'd10, 32'd15, 1'b1);
    total++; if (Y !== 32'hFFFF_FFFB) begin bad++; $display("FAIL borrow_Y got=%h exp=%h", Y, 32'hFFFF_FFFB); end
    total++; if (carry !== 1'b0)      begin bad++; $display("FAIL borrow_carry got=%b exp=0", carry); end
    total++; if (negative !== 1'b1)   begin bad++; $display("FAIL borrow_negative got=%b exp=1", negative); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL borrow_overflow got=%b exp=0", overflow); end
    step(32'h7FFF_FFFF, 32'd1, 1'b0);
    total++; if (Y !== 32'h8000_0000) begin bad++; $display("FAIL addovf_Y got=%h exp=%h", Y, 32'h8000_0000); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL addovf_overflow got=%b exp=1", overflow); end
    total++; if (carry !== 1'b0)      begin bad++; $display("FAIL addovf_carry got=%b exp=0", carry); end
    total++; if (negative !== 1'b1)   begin bad++; $display("FAIL addovf_negative got=%b exp=1", negative); end
  endtask

  task automatic test_sub_overflow_and_zero;
    step(32'h8000_0000, 32'd1, 1'b1);
    total++; if (Y !== 32'h7FFF_FFFF) begin bad++; $display("FAIL subovf_Y got=%h exp=%h", Y, 32'h7FFF_FFFF); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL subovf_overflow got=%b exp=1", overflow); end
    total++; if (carry !== 1'b1)      begin bad++; $display("FAIL subovf_carry got=%b exp=1", carry); end
    step(32'h1234_5678, 32'h1234_5678, 1'b1);
    total++; if (Y !== 32'h0)         begin bad++; $display("FAIL selfsub_Y got=%h exp=%h", Y, 32'h0); end
    total++; if (zero !== 1'b1)       begin bad++; $display("FAIL selfsub_zero got=%b exp=1", zero); end
    total++; if (carry !== 1'b1)      begin bad++; $display("FAIL selfsub_carry got=%b exp=1", carry); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL selfsub_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_boundaries;
    step(32'h0, 32'd1, 1'b1);
    total++; if (Y !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_minus_one_Y got=%h exp=%h", Y, 32'hFFFF_FFFF); end
    total++; if (carry !== 1'b0)      begin bad++; $display("FAIL zero_minus_one_carry got=%b exp=0", carry); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL zero_minus_one_overflow got=%b exp=0", overflow); end
    step(32'hFFFF_FFFF, 32'd1, 1'b0);
    total++; if (Y !== 32'h0)         begin bad++; $display("FAIL wrap_Y got=%h exp=%h", Y, 32'h0); end
    total++; if (carry !== 1'b1)      begin bad++; $display("FAIL wrap_carry got=%b exp=1", carry); end
    total++; if (zero !== 1'b1)       begin bad++; $display("FAIL wrap_zero got=%b exp=1", zero); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ra, rb, ey;
    logic        rr, ec, eo;
    longint      sa, sb, sr;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 1) rb = ra;
      if (i % 6 == 3) ra = 32'h8000_0000;
      rr = i[0];
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      if (rr) begin
        ey = ra - rb;
        ec = (ra >= rb);
        sr = sa - sb;
      end else begin
        ey = ra + rb;
        ec = ({1'b0, ra} + {1'b0, rb}) > 33'h0_FFFF_FFFF;
        sr = sa + sb;
      end
      eo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      step(ra, rb, rr);
      total++;
      if ({Y, carry, overflow, zero, negative} !== {ey, ec, eo, (ey == 32'h0), ey[31]}) begin
        bad++;
        $display("FAIL b2b_%0d got Y=%h c=%b o=%b z=%b n=%b exp Y=%h c=%b o=%b z=%b n=%b",
                 i, Y, carry, overflow, zero, negative, ey, ec, eo, (ey == 32'h0), ey[31]);
      end
    end
    rst = 1'b1;
    step(32'h7FFF_FFFF, 32'd1, 1'b0);
    rst = 1'b0;
    total++;
    if ({Y, carry, overflow, zero, negative} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL midreset got Y=%h c=%b o=%b z=%b n=%b exp Y=00000000 c=0 o=0 z=1 n=0",
               Y, carry, overflow, zero, negative);
    end
    step(32'd100, 32'd58, 1'b1);
    total++;
    if ({Y, carry, overflow, zero, negative} !== {32'd42, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL postreset got Y=%h c=%b o=%b z=%b n=%b exp Y=0000002a c=1 o=0 z=0 n=0",
               Y, carry, overflow, zero, negative);
    end
  endtask

  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    resta = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_borrow_and_add_overflow;
    test_sub_overflow_and_zero;
    test_boundaries;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
